// File: rtl/nway_mux_pipe.sv
// nway_mux_pipe: registered M:1 N-bit mux stage with valid/ready handshake and a
// two-entry skid buffer so in_ready comes straight from a flop.
module nway_mux_pipe #(
  parameter int N     = 32,
  parameter int M     = 4,
  parameter int SEL_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*M-1:0]   in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);
  logic [N-1:0] beat, main_d, main_q, skid_d, skid_q;
  logic mv_d, mv_q, sv_d, sv_q, rdy_q, acc, take;
  always_comb begin
    beat = '0;
    for (int k = 0; k < M; k++)
      if (int'(in_sel) == k) beat = in_data[k*N +: N];
  end
  assign acc  = in_valid && rdy_q;
  // main is free when empty or being consumed this cycle
  assign take = !mv_q || out_ready;
  always_comb begin
    main_d = take && sv_q ? skid_q : (take && acc ? beat : main_q);
    mv_d   = !flush && (take ? (sv_q || acc) : 1'b1);
    skid_d = acc ? beat : skid_q;
    sv_d   = !flush && (take ? (sv_q && acc) : (sv_q || acc));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      mv_q   <= mv_d;
      sv_q   <= sv_d;
      rdy_q  <= !sv_d;
    end
  end
  assign out_data  = main_q;
  assign out_valid = mv_q;
  assign in_ready  = rdy_q;
  assign level     = {1'b0, mv_q} + {1'b0, sv_q};
endmodule

// File: tb/tb_nway_mux_pipe.sv
// tb_nway_mux_pipe: directed plus random stimulus against a queue-based model of
// the held beats; a second M=3 instance covers the out-of-range select.
module tb_nway_mux_pipe;
  logic        clk = 0, rst_n = 0;
  logic [31:0] ch [4];
  logic [127:0] in_data;
  logic [1:0]  in_sel = 0;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] out_data;
  logic [1:0]  level;
  logic [95:0] in_data3;
  logic [1:0]  sel3 = 0, level3;
  logic        valid3 = 0, ready3, out_valid3, ordy3 = 1;
  logic [31:0] out_data3;
  logic [31:0] mq [$];
  logic        m_rdy = 0;
  int          checks = 0, errors = 0, got = 0, sent = 0;

  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  nway_mux_pipe #(.N(32), .M(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level));

  nway_mux_pipe #(.N(32), .M(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(sel3), .in_valid(valid3),
    .in_ready(ready3), .flush(1'b0), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(ordy3), .level(level3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic a, c;
    logic [31:0] b;
    a = in_valid && m_rdy;
    c = (mq.size() > 0) && out_ready;
    b = ch[in_sel];
    chk("no_full_swap", {31'b0, in_valid && in_ready && out_valid && out_ready && level == 2'd2}, 0);
    if (out_valid && out_ready && rst_n && !flush) got++;
    if (a && rst_n) sent++;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_rdy = 0;
    end else if (flush) begin
      mq.delete();
      m_rdy = 1;
    end else begin
      if (c) void'(mq.pop_front());
      if (a) mq.push_back(b);
      m_rdy = mq.size() < 2;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("level", {30'b0, level}, mq.size());
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
  endtask

  task automatic drive(input logic v, input logic r, input logic f);
    in_valid = v;
    out_ready = r;
    flush = f;
    for (int k = 0; k < 4; k++) ch[k] = $urandom;
    in_sel = 2'($urandom_range(0, 3));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ch[k] = 0;
    in_data3 = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", out_data, 0);
      step();
      chk("rst_data_edge", out_data, 0);
    end
    rst_n = 1;
    step();
    chk("ready_after_rst", {31'b0, in_ready}, 1);

    ch[0] = 32'h1111_1111; ch[1] = 32'h2222_2222; ch[2] = 32'h3333_3333; ch[3] = 32'h4444_4444;
    in_valid = 1; out_ready = 1;
    sel3 = 3; valid3 = 1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      step();
      chk("sweep", out_data, 32'h1111_1111 * (i + 1));
      if (i == 0) begin
        chk("oor_valid", {31'b0, out_valid3}, 1);
        chk("oor_data", out_data3, 0);
        sel3 = 2;
      end
      if (i == 1) chk("m3_ch2", out_data3, 32'hCCCC_CCCC);
    end
    valid3 = 0;
    in_valid = 0;
    step();

    got = 0; sent = 0;
    drive(1, 1, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(sent < 4, 0, 0);
      step();
    end
    chk("stall_level", {30'b0, level}, 2);
    chk("stall_ready", {31'b0, in_ready}, 0);
    for (int i = 0; i < 6; i++) begin
      drive(sent < 4, 1, 0);
      step();
    end
    step();
    chk("stall_sent", sent, 4);
    chk("stall_got", got, 4);

    drive(1, 0, 0); step();
    drive(1, 0, 0); step();
    chk("pre_flush_level", {30'b0, level}, 2);
    drive(1, 1, 1); step();
    chk("flush_level", {30'b0, level}, 0);
    chk("flush_ready", {31'b0, in_ready}, 1);
    drive(0, 1, 0); step();
    chk("flush_no_beat", {31'b0, out_valid}, 0);

    drive(1, 0, 0); step();
    drive(1, 0, 0); step();
    chk("pre_arst_level", {30'b0, level}, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_level", {30'b0, level}, 0);
    chk("arst_ready", {31'b0, in_ready}, 0);
    chk("arst_data", out_data, 0);
    drive(0, 1, 0);
    step();
    step();
    #3 rst_n = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 1, 0);
      step();
    end

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
